// File: rtl/adbg_tap_ctrl.sv
// IEEE 1149.1 TAP controller for the debug interface: 16-state FSM, instruction
// register, IDCODE and bypass data registers, and the TDO return mux.
module adbg_tap_ctrl #(
    parameter int                IR_LEN       = 4,
    parameter logic [31:0]       IDCODE_VALUE = 32'h149511C3,
    parameter logic [IR_LEN-1:0] IDCODE_INSTR = 4'h2,
    parameter logic [IR_LEN-1:0] DEBUG_INSTR  = 4'h8,
    parameter logic [IR_LEN-1:0] BYPASS_INSTR = 4'hF
) (
    input  logic tck_i,
    input  logic rst_i,
    input  logic tms_i,
    input  logic tdi_i,
    output logic tdo_o,
    output logic tdo_oe_o,
    input  logic debug_tdo_i,
    output logic capture_dr_o,
    output logic shift_dr_o,
    output logic pause_dr_o,
    output logic update_dr_o,
    output logic test_logic_reset_o,
    output logic debug_select_o
);

    typedef enum logic [3:0] {
        S_TLR,    S_RTI,
        S_SEL_DR, S_CAP_DR, S_SH_DR, S_EX1_DR, S_PAU_DR, S_EX2_DR, S_UPD_DR,
        S_SEL_IR, S_CAP_IR, S_SH_IR, S_EX1_IR, S_PAU_IR, S_EX2_IR, S_UPD_IR
    } state_t;

    // Capture-IR pattern: LSBs 2'b01 so a broken scan chain is detectable.
    localparam logic [IR_LEN-1:0] IR_CAPTURE = {{(IR_LEN-1){1'b0}}, 1'b1};

    state_t            r_state;
    state_t            w_next;
    logic [IR_LEN-1:0] r_ir;
    logic [IR_LEN-1:0] r_ir_shift;
    logic [31:0]       r_idcode;
    logic              r_bypass;

    logic w_sel_idcode;
    logic w_sel_debug;
    logic w_sel_bypass;

    assign w_sel_idcode = (r_ir == IDCODE_INSTR);
    assign w_sel_debug  = (r_ir == DEBUG_INSTR);
    // Explicit bypass opcode and every unassigned opcode share the bypass path.
    assign w_sel_bypass = !w_sel_idcode && !w_sel_debug;

    always_ff @(posedge tck_i) begin
        if (rst_i) begin
            r_state <= S_TLR;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_TLR:    w_next = tms_i ? S_TLR    : S_RTI;
            S_RTI:    w_next = tms_i ? S_SEL_DR : S_RTI;
            S_SEL_DR: w_next = tms_i ? S_SEL_IR : S_CAP_DR;
            S_CAP_DR: w_next = tms_i ? S_EX1_DR : S_SH_DR;
            S_SH_DR:  w_next = tms_i ? S_EX1_DR : S_SH_DR;
            S_EX1_DR: w_next = tms_i ? S_UPD_DR : S_PAU_DR;
            S_PAU_DR: w_next = tms_i ? S_EX2_DR : S_PAU_DR;
            S_EX2_DR: w_next = tms_i ? S_UPD_DR : S_SH_DR;
            S_UPD_DR: w_next = tms_i ? S_SEL_DR : S_RTI;
            S_SEL_IR: w_next = tms_i ? S_TLR    : S_CAP_IR;
            S_CAP_IR: w_next = tms_i ? S_EX1_IR : S_SH_IR;
            S_SH_IR:  w_next = tms_i ? S_EX1_IR : S_SH_IR;
            S_EX1_IR: w_next = tms_i ? S_UPD_IR : S_PAU_IR;
            S_PAU_IR: w_next = tms_i ? S_EX2_IR : S_PAU_IR;
            S_EX2_IR: w_next = tms_i ? S_UPD_IR : S_SH_IR;
            S_UPD_IR: w_next = tms_i ? S_SEL_DR : S_RTI;
            default:  w_next = S_TLR;
        endcase
    end

    always_ff @(posedge tck_i) begin
        if (rst_i) begin
            r_ir       <= IDCODE_INSTR;
            r_ir_shift <= '0;
        end else begin
            case (r_state)
                S_TLR:    r_ir       <= IDCODE_INSTR;
                S_CAP_IR: r_ir_shift <= IR_CAPTURE;
                S_SH_IR:  r_ir_shift <= {tdi_i, r_ir_shift[IR_LEN-1:1]};
                S_UPD_IR: r_ir       <= r_ir_shift;
                default:  ;
            endcase
        end
    end

    // Data registers move only in Capture/Shift-DR and only when selected.
    always_ff @(posedge tck_i) begin
        if (rst_i) begin
            r_idcode <= '0;
            r_bypass <= 1'b0;
        end else begin
            if (w_sel_idcode) begin
                if (r_state == S_CAP_DR) r_idcode <= IDCODE_VALUE;
                else if (r_state == S_SH_DR) r_idcode <= {tdi_i, r_idcode[31:1]};
            end
            if (w_sel_bypass) begin
                if (r_state == S_CAP_DR) r_bypass <= 1'b0;
                else if (r_state == S_SH_DR) r_bypass <= tdi_i;
            end
        end
    end

    always_comb begin
        tdo_o = 1'b0;
        if (r_state == S_SH_IR) begin
            tdo_o = r_ir_shift[0];
        end else if (r_state == S_SH_DR) begin
            if (w_sel_idcode)     tdo_o = r_idcode[0];
            else if (w_sel_debug) tdo_o = debug_tdo_i;
            else                  tdo_o = r_bypass;
        end
    end

    assign tdo_oe_o           = (r_state == S_SH_IR) || (r_state == S_SH_DR);
    assign capture_dr_o       = (r_state == S_CAP_DR);
    assign shift_dr_o         = (r_state == S_SH_DR);
    assign pause_dr_o         = (r_state == S_PAU_DR);
    assign update_dr_o        = (r_state == S_UPD_DR);
    assign test_logic_reset_o = (r_state == S_TLR);
    assign debug_select_o     = w_sel_debug;

endmodule

// File: doc/adbg_tap_ctrl.md
ADBG_TAP_CTRL -- requirements
Module: adbg_tap_ctrl

Interface
REQ-001 SHALL have parameter IR_LEN, default 4, instruction register width (>=2).
REQ-002 SHALL have parameter IDCODE_VALUE, default 32'h149511C3, device ID returned by the IDCODE instruction; bit 0 is 1.
REQ-003 SHALL have parameter IDCODE_INSTR, default 4'h2, opcode selecting the IDCODE data register.
REQ-004 SHALL have parameter DEBUG_INSTR, default 4'h8, opcode selecting the debug chain.
REQ-005 SHALL have parameter BYPASS_INSTR, default 4'hF, opcode selecting the 1-bit bypass register.
REQ-006 SHALL have port tck_i  input  1  sole clock; all state updates on its rising edge.
REQ-007 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-008 SHALL have port tms_i  input  1  JTAG test mode select.
REQ-009 SHALL have port tdi_i  input  1  JTAG serial data in.
REQ-010 SHALL have port tdo_o  output  1  JTAG serial data out, combinational mux.
REQ-011 SHALL have port tdo_oe_o  output  1  high in Shift-IR or Shift-DR.
REQ-012 SHALL have port debug_tdo_i  input  1  serial return from the debug top-level.
REQ-013 SHALL have ports capture_dr_o, shift_dr_o, pause_dr_o, update_dr_o  output  1 each  high while the FSM is in the named state.
REQ-014 SHALL have port test_logic_reset_o  output  1  high in Test-Logic-Reset.
REQ-015 SHALL have port debug_select_o  output  1  high when the latched instruction equals DEBUG_INSTR.

Function
REQ-016 SHALL implement the 16-state IEEE 1149.1 FSM (TLR, RTI, Select-DR, Capture-DR, Shift-DR, Exit1-DR, Pause-DR, Exit2-DR, Update-DR, and the IR equivalents) with transitions on tms_i at each rising tck_i.
REQ-017 SHALL reach TLR from any state after five consecutive rising edges with tms_i=1.
REQ-018 State-flag outputs SHALL decode the current-state register combinationally, with no added latency.
REQ-019 In Capture-IR, ir_shift SHALL load {IR_LEN-2 zeros..., 2'b01} (4'b0001 at IR_LEN=4).
REQ-020 In Shift-IR, ir_shift SHALL shift right, tdi_i into the MSB; tdo_o = ir_shift[0].
REQ-021 In Update-IR, ir_reg SHALL load ir_shift; in TLR, ir_reg SHALL load IDCODE_INSTR.
REQ-022 Any opcode other than IDCODE_INSTR or DEBUG_INSTR SHALL select bypass.
REQ-023 IDCODE: Capture-DR SHALL load a 32-bit register with IDCODE_VALUE; Shift-DR SHALL shift it right, tdi_i into bit 31; tdo_o = bit 0.
REQ-024 Bypass: Capture-DR SHALL clear a 1-bit register; Shift-DR SHALL load it with tdi_i; tdo_o = that bit (one-tck delay).
REQ-025 Debug: in Shift-DR, tdo_o SHALL equal debug_tdo_i; no local register shifts.
REQ-026 Outside Shift-IR/Shift-DR, tdo_o SHALL be 0.
REQ-027 Registers not selected by ir_reg SHALL hold their value during DR operations.
REQ-028 ir_reg SHALL change only in Update-IR or TLR; Pause/Exit states SHALL hold all shift registers.

Reset
REQ-029 rst_i=1 at a rising edge SHALL force the FSM to TLR, set ir_reg=IDCODE_INSTR, and clear ir_shift, the IDCODE shift register, and bypass; this overrides tms_i.
REQ-030 After reset: test_logic_reset_o=1, all other flags 0, debug_select_o=0, tdo_o=0, tdo_oe_o=0.
REQ-031 Reset asserted mid-shift SHALL abort the shift; no Update-IR/Update-DR pulse SHALL occur.

Verification
REQ-032 Reset, then TMS 0,1,0,0, shift 32 bits -> tdo_o yields 32'h149511C3 LSB first; tdo_oe_o=1 for 32 cycles.
REQ-033 Load IR 4'h8 via Shift-IR -> capture bits read 1,0,0,0 on tdo_o; after Update-IR, debug_select_o=1; in Shift-DR, tdo_o tracks debug_tdo_i cycle-for-cycle.
REQ-034 Load IR 4'hF, shift tdi pattern 1,0,1,1 -> tdo_o shows 0,1,0,1 (one-cycle delay, leading 0).
REQ-035 Starting in each of the 16 states, apply five tms_i=1 edges -> TLR; ir_reg=4'h2.
REQ-036 Enter Shift-DR, then Exit1-DR, Pause-DR x3, Exit2-DR, Shift-DR -> pause_dr_o high for exactly 3 cycles; IDCODE shift continues without lost bits.
REQ-037 Assert rst_i during Shift-IR after 2 of 4 bits -> ir_reg=4'h2, no update_dr_o pulse, test_logic_reset_o=1 on the next cycle.
